// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants and types for the traffic light controller.
//   - state_t     : controller FSM state encoding
//   - cfg_entry_t : one light's configuration {red_time, green_time, start}
//   - NUM_LIGHTS, DEFAULT_TIME, LAST_IDX : table size, reset time, last broadcast index
//   - entry_time(): selects the red or green time of an entry
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] red_time;
        logic [3:0] green_time;
        logic       start;
    } cfg_entry_t;

    localparam int         NUM_LIGHTS   = 4;
    localparam logic [3:0] DEFAULT_TIME = 4'd10;
    localparam logic [2:0] LAST_IDX     = 3'd7;

    // Colour select: 1 = green time, 0 = red time.
    function automatic logic [3:0] entry_time(input cfg_entry_t e, input logic color);
        logic [3:0] t;
        if (color) begin
            t = e.green_time;
        end else begin
            t = e.red_time;
        end
        return t;
    endfunction

endpackage

// File: rtl/traffic_cfg_table.sv
// traffic_cfg_table: 4-entry configuration register file.
// Synchronous write of one time field plus the start bit; combinational read.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (restores defaults)
//   i_wr_en       : write strobe (already qualified by the controller)
//   i_wr_sel      : entry to write
//   i_wr_color    : 1 = write green time, 0 = write red time
//   i_wr_start    : start colour to store
//   i_wr_time     : time value to store
//   i_rd_sel      : entry to read
//   o_rd_entry    : entry contents (combinational)
module traffic_cfg_table
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [1:0] i_wr_sel,
    input  logic       i_wr_color,
    input  logic       i_wr_start,
    input  logic [3:0] i_wr_time,
    input  logic [1:0] i_rd_sel,
    output cfg_entry_t o_rd_entry
);

    cfg_entry_t r_table [NUM_LIGHTS];

    // Table storage: defaults on reset, single-field update on write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                r_table[i].red_time   <= DEFAULT_TIME;
                r_table[i].green_time <= DEFAULT_TIME;
                r_table[i].start      <= 1'b0;
            end
        end else if (i_wr_en) begin
            r_table[i_wr_sel].start <= i_wr_start;
            if (i_wr_color) begin
                r_table[i_wr_sel].green_time <= i_wr_time;
            end else begin
                r_table[i_wr_sel].red_time <= i_wr_time;
            end
        end
    end

    assign o_rd_entry = r_table[i_rd_sel];

endmodule

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: instruction-issuing controller for four traffic lights.
// Holds the configuration table and, on go, broadcasts all 8 time values as
// inst_send pulses separated by one idle cycle, then raises is_running.
// Optional feature: define TRAFFIC_CTRL_AUTOSTART_EN to treat the first cycle
// after reset as a go.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   wr_en/wr_sel/wr_color/
//   wr_start/wr_time              : table write request
//   go, stop                      : broadcast-and-run / halt pulses
//   inst_send, traffic_sel,
//   color_sel, start_color,
//   input_time                    : instruction bus to the lights (registered)
//   is_running, busy, wr_err      : status (registered)
module traffic_ctrl
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic       wr_color,
    input  logic       wr_start,
    input  logic [3:0] wr_time,
    input  logic       go,
    input  logic       stop,
    output logic       inst_send,
    output logic [1:0] traffic_sel,
    output logic       color_sel,
    output logic       start_color,
    output logic [3:0] input_time,
    output logic       is_running,
    output logic       busy,
    output logic       wr_err
);

    state_t     r_state;
    logic [2:0] r_idx;
    logic       r_inst_send;
    logic [1:0] r_traffic_sel;
    logic       r_color_sel;
    logic       r_start_color;
    logic [3:0] r_input_time;
    logic       r_is_running;
    logic       r_busy;
    logic       r_wr_err;

    logic       w_go;
    logic       w_wr_ok;
    logic [2:0] w_next_idx;
    logic [1:0] w_rd_sel;
    logic       w_rd_color;
    cfg_entry_t w_tbl_entry;
    cfg_entry_t w_entry;
    logic [3:0] w_time;

`ifdef TRAFFIC_CTRL_AUTOSTART_EN
    logic r_autostart;

    // Flags the first cycle after reset so it acts as a go.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_autostart <= 1'b1;
        end else begin
            r_autostart <= 1'b0;
        end
    end

    assign w_go = go | r_autostart;
`else
    assign w_go = go;
`endif

    // Writes are dropped while a broadcast is in flight so it stays consistent.
    assign w_wr_ok = wr_en && (wr_time != 4'd0) && !r_busy;

    traffic_cfg_table u_table (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_ok),
        .i_wr_sel   (wr_sel),
        .i_wr_color (wr_color),
        .i_wr_start (wr_start),
        .i_wr_time  (wr_time),
        .i_rd_sel   (w_rd_sel),
        .o_rd_entry (w_tbl_entry)
    );

    // Index of the pulse that would be launched at the next edge, plus the
    // entry it carries; a write committing at that same edge is forwarded so
    // go-with-write in the same cycle already sends the new value.
    always_comb begin
        w_next_idx = 3'd0;
        w_entry    = w_tbl_entry;
        if (r_state == ST_GAP) begin
            w_next_idx = r_idx + 3'd1;
        end else begin
            w_next_idx = 3'd0;
        end
        w_rd_sel   = w_next_idx[2:1];
        w_rd_color = w_next_idx[0];
        if (w_wr_ok && (wr_sel == w_rd_sel)) begin
            w_entry.start = wr_start;
            if (wr_color) begin
                w_entry.green_time = wr_time;
            end else begin
                w_entry.red_time = wr_time;
            end
        end else begin
            w_entry = w_tbl_entry;
        end
        w_time = entry_time(w_entry, w_rd_color);
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_inst_send   <= 1'b0;
            r_traffic_sel <= 2'd0;
            r_color_sel   <= 1'b0;
            r_start_color <= 1'b0;
            r_input_time  <= 4'd0;
            r_is_running  <= 1'b0;
            r_busy        <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_wr_err    <= wr_en && ((wr_time == 4'd0) || r_busy);
            r_inst_send <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (stop) begin
                        r_state      <= ST_IDLE;
                        r_is_running <= 1'b0;
                        r_busy       <= 1'b0;
                    end else if (w_go) begin
                        r_state       <= ST_SEND;
                        r_idx         <= w_next_idx;
                        r_inst_send   <= 1'b1;
                        r_traffic_sel <= w_rd_sel;
                        r_color_sel   <= w_rd_color;
                        r_start_color <= w_entry.start;
                        r_input_time  <= w_time;
                        r_is_running  <= 1'b0;
                        r_busy        <= 1'b1;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_SEND: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_idx == LAST_IDX) begin
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b0;
                        r_is_running <= 1'b1;
                    end else begin
                        r_state       <= ST_SEND;
                        r_idx         <= w_next_idx;
                        r_inst_send   <= 1'b1;
                        r_traffic_sel <= w_rd_sel;
                        r_color_sel   <= w_rd_color;
                        r_start_color <= w_entry.start;
                        r_input_time  <= w_time;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_is_running <= 1'b0;
                end
            endcase
        end
    end

    assign inst_send   = r_inst_send;
    assign traffic_sel = r_traffic_sel;
    assign color_sel   = r_color_sel;
    assign start_color = r_start_color;
    assign input_time  = r_input_time;
    assign is_running  = r_is_running;
    assign busy        = r_busy;
    assign wr_err      = r_wr_err;

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Instruction-issuing controller for the four `traffic_light` instances; the sending side of their `inst_send` configuration interface. Holds a table of red/green times and start colours, updated by user writes. On `go` it broadcasts the whole table as a paced sequence of `inst_send` pulses, then raises `is_running` to start all lights. Sits between debounced board inputs and the shared light bus.

## Interface
Parameters:
- none (constants live in `traffic_pkg`)

Ports:
- clk  in  1  system clock (one clock domain)
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  single-cycle write strobe (debounced)
- wr_sel  in  2  light index to write
- wr_color  in  1  1 = write green time, 0 = write red time
- wr_start  in  1  start colour to store for `wr_sel`
- wr_time  in  4  phase time in seconds, 1..15
- go  in  1  single-cycle pulse: broadcast table, then run
- stop  in  1  single-cycle pulse: halt lights
- inst_send  out  1  single-cycle instruction strobe
- traffic_sel  out  2  target light of the current instruction
- color_sel  out  1  1 = green time, 0 = red time
- start_color  out  1  start colour for the target light
- input_time  out  4  time value for the instruction
- is_running  out  1  lights counting
- busy  out  1  broadcast in progress
- wr_err  out  1  one-cycle pulse: write rejected

## Operation
- Table: 4 entries of {red_time[3:0], green_time[3:0], start[0]}. Reset/default is red = green = 10, start = 0, matching the light's own reset state.
- Write (`wr_en`), accepted in IDLE and RUN:
  - updates the `wr_color`-selected time and `start` of entry `wr_sel`;
  - takes effect on the next broadcast, not on the running lights.
- Rejected writes leave the table unchanged and pulse `wr_err`:
  - `wr_time == 0`;
  - a write arriving while `busy` is high.
- Broadcast order: index k = 0..7, with `traffic_sel = k[2:1]` and `color_sel = k[0]` (red first, then green). `start_color` = that light's stored start bit on both of its pulses.
- FSM states: IDLE, SEND, GAP, RUN.
- FSM transitions:
  - IDLE --go--> SEND(k=0)
  - SEND → GAP
  - GAP → SEND(k+1) if k < 7, else RUN
  - RUN --go--> SEND(k=0), which re-broadcasts and drops `is_running`
  - RUN --stop--> IDLE
  - SEND/GAP --stop--> IDLE (abort)
- `go` is ignored while in SEND or GAP.
- Outputs: `inst_send` = 1 only in SEND. `busy` = 1 in SEND/GAP. `is_running` = 1 only in RUN.
- Simultaneous events:
  - `stop` and `go` in the same cycle: `stop` wins.
  - `wr_en` and `go` in the same cycle in IDLE: the write commits and the broadcast carries the new value.

## Timing
- All outputs are registered.
- Reset values: `inst_send`, `traffic_sel`, `color_sel`, `start_color`, `input_time`, `is_running`, `busy`, `wr_err` all 0; FSM in IDLE.
- `go` high in cycle t:
  - `inst_send` high in cycles t+1, t+3, …, t+15;
  - `busy` high in t+1..t+16;
  - `is_running` high from t+17.
- The data outputs (`traffic_sel`, `color_sel`, `start_color`, `input_time`) are valid in every cycle `inst_send` is high, and hold their last value otherwise.
- The GAP cycle guarantees `inst_send` never stays high for two consecutive cycles.
- `wr_err` is high the cycle after the rejected `wr_en`.
- `stop` in cycle t: `is_running`/`busy` are 0 from t+1, and no further `inst_send`.
- `rst` mid-broadcast: outputs reach their reset values at the next edge, the table returns to defaults, and the remaining pulses are not sent.

## Configuration
- `TRAFFIC_CTRL_AUTOSTART_EN` defined: the cycle after `rst` deasserts behaves as a `go`. The default table is broadcast and the lights run with no user action.
- Undefined: the controller stays in IDLE until the first `go`.

## Structure
- `traffic_pkg` holds:
  - FSM state encoding;
  - `NUM_LIGHTS = 4`, `DEFAULT_TIME = 4'd10`, `LAST_IDX = 3'd7`.
- Sub-module `traffic_cfg_table`: 4-entry register file with a synchronous write port and a combinational read by index, including reset defaults.
- The FSM and output registers live in `traffic_ctrl`.

## Test plan
- Reset, then `go` at t=5 → 8 `inst_send` pulses at t=6,8,…,20, all with `input_time = 10` and `start_color = 0`; `is_running` = 1 from t=22.
- Write light 2 green = 3 with `wr_start = 1`, then `go` → the pulse with k=5 carries `traffic_sel = 2`, `color_sel = 1`, `input_time = 3`, `start_color = 1`; k=4 also carries `start_color = 1`.
- Write with `wr_time = 0` → `wr_err` pulses one cycle; the next broadcast still sends 10 for that entry.
- `stop` in the cycle after the third pulse → no further `inst_send`, `busy` = 0, `is_running` never rises.
- `go` and `stop` in the same cycle while in RUN → IDLE with `is_running` = 0 and no pulses; `rst` asserted mid-broadcast → all outputs 0 and the table back to defaults.
- Built with `TRAFFIC_CTRL_AUTOSTART_EN` → 8 pulses start with no `go`; `is_running` is high 17 cycles after the first post-reset cycle.
